lbm_stream_sched: RTL and testbench
===================================

LBM_STREAM_SCHED -- requirements
Module: lbm_stream_sched

Interface
REQ-001 SHALL have parameter NX, default 16, meaning lattice width in cells (power of two, ≥2).
REQ-002 SHALL have parameter NY, default 16, meaning lattice height in cells (power of two, ≥2).
REQ-003 SHALL have parameter WIDTH, default 64*9, meaning packed width of the velocity-constant vectors.
REQ-004 SHALL have parameter ADDR_W, default $clog2(NX*NY), meaning cell address width.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port Start, input, 1, one-cycle request to begin a full streaming pass.
REQ-008 SHALL have port Cx_In, input, WIDTH, signed 8.56 x-velocity constants, direction q in bits [(8-q)*64+63 : (8-q)*64].
REQ-009 SHALL have port Cy_In, input, WIDTH, signed 8.56 y-velocity constants, same packing as Cx_In.
REQ-010 SHALL have port Req_Ready, input, 1, downstream accepts the current request.
REQ-011 SHALL have port Req_Valid, output, 1, a streaming request is presented.
REQ-012 SHALL have port Src_Addr, output, ADDR_W, source cell address y*NX+x.
REQ-013 SHALL have port Dst_Addr, output, ADDR_W, destination (neighbour) cell address.
REQ-014 SHALL have port Dir, output, 4, direction index q (0..8).
REQ-015 SHALL have port Busy, output, 1, pass in progress.
REQ-016 SHALL have port Done, output, 1, one-cycle pass-complete pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, FINISH; IDLE->ISSUE on Start; ISSUE->FINISH on the final handshake; FINISH->IDLE unconditionally after one cycle.
REQ-018 SHALL assert Req_Valid and Busy only in ISSUE, from the cycle after Start is sampled.
REQ-019 SHALL treat a handshake as Req_Valid & Req_Ready at a rising edge; Src_Addr, Dst_Addr, Dir SHALL hold stable while Req_Valid=1 and Req_Ready=0.
REQ-020 SHALL allow one handshake per cycle with no bubbles while Req_Ready stays high.
REQ-021 SHALL order requests q innermost (0..8), then x (0..NX-1), then y outermost (0..NY-1); total NX*NY*9 handshakes per pass.
REQ-022 SHALL derive offset dx/dy from the signed integer byte [63:56] of the direction's word, saturated to -1..+1; fraction bits ignored.
REQ-023 SHALL compute destination x' = (x+dx) mod NX, y' = (y+dy) mod NY (periodic wrap both edges), Dst_Addr = y'*NX+x'.
REQ-024 SHALL sample Cx_In/Cy_In combinationally per request; changes during a pass take effect on the next presented request.
REQ-025 SHALL ignore Start while Busy=1 or in FINISH.
REQ-026 SHALL assert Done for exactly one cycle (FINISH), the cycle after the final handshake; Busy=0 in that cycle.

Reset
REQ-027 SHALL, on Reset=1, immediately force IDLE, Req_Valid=0, Busy=0, Done=0, Src_Addr=0, Dst_Addr=0, Dir=0, counters cleared, regardless of clock.
REQ-028 SHALL, on Reset mid-pass, abandon the pass with no Done pulse; next Start begins at cell (0,0), q=0.

Verification (NX=NY=4, D2Q9 constants cx={0,1,0,-1,0,1,-1,-1,1}, cy={0,0,1,0,-1,1,1,-1,-1})
REQ-029 SHALL cover: Start pulse, Req_Ready held 1 -> 144 consecutive handshakes, first Src=0,Dst=0,Dir=0, Done one cycle after 144th, Busy low thereafter.
REQ-030 SHALL cover: cell (3,0), Dir=1 -> Src=3, Dst=0 (x wrap); cell (0,0), Dir=7 -> Src=0, Dst=15 (x and y wrap).
REQ-031 SHALL cover: cell (1,3), Dir=2 -> Src=13, Dst=1 (y wrap); cell (2,1), Dir=8 -> Src=6, Dst=3.
REQ-032 SHALL cover: Req_Ready random 50% -> outputs stable during stalls, still exactly 144 handshakes, sequence identical to REQ-029.
REQ-033 SHALL cover: second Start during pass ignored; Reset asserted after 50 handshakes -> all outputs 0 asynchronously, no Done; new Start restarts at Src=0,Dir=0.
REQ-034 SHALL cover: Cx_In word q=1 set to integer +3 -> dx saturated to +1, Dst identical to nominal.

Source files
------------

// File: rtl/lbm_stream_sched.sv
// -----------------------------------------------------------------------------
// lbm_stream_sched
//
// Generates the address stream for one lattice-Boltzmann streaming pass.
// For every cell (x, y) and every direction q it presents one request: the
// source cell, the periodic-wrapped neighbour cell, and q. Direction q is the
// innermost loop, then x, then y.
//
// Ports
//   Clk        : single clock, rising-edge active
//   Reset      : asynchronous, active-high
//   Start      : one-cycle pulse that begins a pass (ignored unless idle)
//   Cx_In      : packed signed 8.56 x-velocities, word q at [(8-q)*64 +: 64]
//   Cy_In      : packed signed 8.56 y-velocities, same packing
//   Req_Ready  : downstream accepts the presented request
//   Req_Valid  : a request is presented
//   Src_Addr   : source cell address y*NX+x
//   Dst_Addr   : neighbour cell address y'*NX+x'
//   Dir        : direction index q (0..8)
//   Busy       : a pass is in progress
//   Done       : one-cycle pulse the cycle after the final handshake
//   Dbg_State  : current FSM state (0 idle, 1 issue, 2 finish)
//
// Handshake: a request transfers on a rising edge where Req_Valid and
// Req_Ready are both 1. While Req_Valid=1 and Req_Ready=0, Src_Addr, Dst_Addr
// and Dir hold. Req_Valid never drops without a transfer except on Reset.
// -----------------------------------------------------------------------------
module lbm_stream_sched #(
  parameter int NX     = 16,
  parameter int NY     = 16,
  parameter int WIDTH  = 64*9,
  parameter int ADDR_W = $clog2(NX*NY)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [WIDTH-1:0]  Cx_In,
  input  logic [WIDTH-1:0]  Cy_In,
  input  logic              Req_Ready,
  output logic              Req_Valid,
  output logic [ADDR_W-1:0] Src_Addr,
  output logic [ADDR_W-1:0] Dst_Addr,
  output logic [3:0]        Dir,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        Dbg_State
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [3:0]    cur_q;
  logic [ADDR_W-1:0] dst_reg;

  // Coordinates of the request that will be presented next: zero when a
  // pass is loaded from idle, otherwise the successor of the current one.
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [3:0]    sel_q;
  logic          last;

  logic signed [7:0] cx_b;
  logic signed [7:0] cy_b;
  logic [XW-1:0]     dst_x;
  logic [YW-1:0]     dst_y;
  logic [ADDR_W-1:0] nxt_dst;

  assign last = (cur_q == 4'd8) && (cur_x == XW'(NX-1)) && (cur_y == YW'(NY-1));

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_q = '0;
    if (state != S_IDLE) begin
      sel_x = cur_x;
      sel_y = cur_y;
      sel_q = cur_q + 4'd1;
      if (cur_q == 4'd8) begin
        sel_q = '0;
        if (cur_x == XW'(NX-1)) begin
          sel_x = '0;
          sel_y = cur_y + YW'(1);
        end else begin
          sel_x = cur_x + XW'(1);
        end
      end
    end
  end

  // Only the integer byte of each 8.56 word matters; constant-index loop
  // keeps the word select free of variable part-selects.
  always_comb begin
    cx_b = '0;
    cy_b = '0;
    for (int i = 0; i < 9; i++) begin
      if (sel_q == 4'(i)) begin
        cx_b = Cx_In[(8-i)*64+56 +: 8];
        cy_b = Cy_In[(8-i)*64+56 +: 8];
      end
    end
  end

  // Offsets saturate to -1/0/+1. Lattice sizes are powers of two, so adding
  // an all-ones value and truncating gives the periodic wrap for -1.
  always_comb begin
    dst_x = sel_x;
    dst_y = sel_y;
    if (cx_b > 8'sd0)      dst_x = sel_x + XW'(1);
    else if (cx_b < 8'sd0) dst_x = sel_x - XW'(1);
    if (cy_b > 8'sd0)      dst_y = sel_y + YW'(1);
    else if (cy_b < 8'sd0) dst_y = sel_y - YW'(1);
    nxt_dst = ADDR_W'({dst_y, dst_x});
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      Req_Valid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      cur_q     <= '0;
      dst_reg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state     <= S_ISSUE;
            Req_Valid <= 1'b1;
            Busy      <= 1'b1;
            cur_x     <= '0;
            cur_y     <= '0;
            cur_q     <= '0;
            dst_reg   <= nxt_dst;
          end
        end
        S_ISSUE: begin
          if (Req_Ready) begin
            if (last) begin
              state     <= S_FINISH;
              Req_Valid <= 1'b0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
            end else begin
              cur_x   <= sel_x;
              cur_y   <= sel_y;
              cur_q   <= sel_q;
              dst_reg <= nxt_dst;
            end
          end
        end
        S_FINISH: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          Req_Valid <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

  assign Src_Addr  = ADDR_W'({cur_y, cur_x});
  assign Dst_Addr  = dst_reg;
  assign Dir       = cur_q;
  assign Dbg_State = state;

endmodule

// File: tb/tb_lbm_stream_sched.sv
module tb_lbm_stream_sched;

  localparam int NX = 4;
  localparam int NY = 4;
  localparam int WIDTH = 64*9;
  localparam int ADDR_W = 4;
  localparam int NREQ = NX*NY*9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [WIDTH-1:0]  cx_in = '0;
  logic [WIDTH-1:0]  cy_in = '0;
  logic              req_ready = 1'b0;
  logic              req_valid;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [3:0]        dir;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  lbm_stream_sched #(.NX(NX), .NY(NY), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Cx_In(cx_in), .Cy_In(cy_in),
    .Req_Ready(req_ready), .Req_Valid(req_valid), .Src_Addr(src_addr),
    .Dst_Addr(dst_addr), .Dir(dir), .Busy(busy), .Done(done),
    .Dbg_State(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [11:0] exp_q[$];
  logic [11:0] cap[NREQ];
  int hs_count = 0;
  int hs_cyc = 0;
  int first_hs_cyc = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  int ready_mode = 1;   // 1: held high, 2: random 50%
  logic signed [7:0] cx_raw[9];
  logic signed [7:0] cy_raw[9];
  int cx_nom[9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int cy_nom[9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  // Hand-computed spot checks: handshake index = (y*NX+x)*9+q
  int spot_idx[4] = '{28, 7, 119, 62};
  int spot_src[4] = '{3, 0, 13, 6};
  int spot_dst[4] = '{0, 15, 1, 3};
  int spot_dir[4] = '{1, 7, 2, 8};

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) req_ready = 1'($urandom_range(0, 1));
    else                 req_ready = 1'b1;
  end

  task automatic set_consts();
    for (int q = 0; q < 9; q++) begin
      cx_in[(8-q)*64 +: 64] = {cx_raw[q], 56'h0};
      cy_in[(8-q)*64 +: 64] = {cy_raw[q], 56'h0};
    end
  endtask

  function automatic int sat(input logic signed [7:0] v);
    if (v > 0) return 1;
    if (v < 0) return -1;
    return 0;
  endfunction

  task automatic push_pass();
    int sx, sy, dx, dy;
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++)
        for (int q = 0; q < 9; q++) begin
          sx = (x + sat(cx_raw[q]) + NX) % NX;
          sy = (y + sat(cy_raw[q]) + NY) % NY;
          dx = y*NX + x;
          dy = sy*NX + sx;
          exp_q.push_back({4'(dx), 4'(dy), 4'(q)});
        end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == base) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no Done within %0d cycles", name, n);
    end
  endtask

  task automatic run_pass(input string name);
    int base;
    base = done_cnt;
    hs_count = 0;
    push_pass();
    pulse_start();
    wait_done(name, base);
    check({name, "_hs_count"}, hs_count, NREQ);
    check({name, "_queue_left"}, exp_q.size(), 0);
    if (ready_mode == 1) check({name, "_no_bubbles"}, hs_cyc - first_hs_cyc, NREQ-1);
    for (int i = 0; i < 4; i++) begin
      check({name, "_spot_src"}, int'(cap[spot_idx[i]][11:8]), spot_src[i]);
      check({name, "_spot_dst"}, int'(cap[spot_idx[i]][7:4]), spot_dst[i]);
      check({name, "_spot_dir"}, int'(cap[spot_idx[i]][3:0]), spot_dir[i]);
    end
    @(negedge clk); #1;
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_after"}, int'(done), 0);
    check({name, "_valid_after"}, int'(req_valid), 0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: src=%0d dst=%0d dir=%0d with empty queue",
                   src_addr, dst_addr, dir);
        end else begin
          if ({src_addr, dst_addr, dir} !== exp_q[0]) begin
            fails++;
            $display("FAIL req_%0d: got src=%0d dst=%0d dir=%0d expected src=%0d dst=%0d dir=%0d",
                     hs_count, src_addr, dst_addr, dir,
                     exp_q[0][11:8], exp_q[0][7:4], exp_q[0][3:0]);
          end
          if (req_ready) begin
            if (hs_count < NREQ) cap[hs_count] = {src_addr, dst_addr, dir};
            if (hs_count == 0) first_hs_cyc = cyc;
            hs_cyc = cyc;
            hs_count++;
            void'(exp_q.pop_front());
          end
        end
        check("busy_with_valid", int'(busy), 1);
      end
      if (done) begin
        tests++;
        if (busy || req_valid || prev_done || cyc != hs_cyc + 1) begin
          fails++;
          $display("FAIL done_pulse: busy=%0d valid=%0d prev_done=%0d cycles_after_last_hs=%0d expected 0/0/0/1",
                   busy, req_valid, prev_done, cyc - hs_cyc);
        end
        done_cnt++;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    for (int q = 0; q < 9; q++) begin
      cx_raw[q] = 8'(cx_nom[q]);
      cy_raw[q] = 8'(cy_nom[q]);
    end
    set_consts();

    // Reset state
    #12;
    check("rst_valid", int'(req_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_src", int'(src_addr), 0);
    check("rst_dst", int'(dst_addr), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_state", int'(dbg_state), 0);
    @(posedge clk); #2 rst = 1'b0;

    // Full pass, ready held high
    ready_mode = 1;
    run_pass("pass_ready_high");

    // Full pass, ready random
    ready_mode = 2;
    run_pass("pass_ready_random");

    // Out-of-range constant saturates: +3 behaves as +1
    ready_mode = 1;
    cx_raw[1] = 8'sd3;
    set_consts();
    run_pass("pass_sat");
    cx_raw[1] = 8'sd1;
    set_consts();

    // Second Start ignored, then asynchronous reset mid-pass
    ready_mode = 1;
    base = done_cnt;
    hs_count = 0;
    push_pass();
    pulse_start();
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    begin
      int n;
      n = 0;
      while (hs_count < 50 && n < 500) begin
        @(posedge clk); #2;
        n++;
      end
    end
    check("hs_before_reset", int'(hs_count >= 50), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(req_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_src", int'(src_addr), 0);
    check("async_rst_dst", int'(dst_addr), 0);
    check("async_rst_dir", int'(dir), 0);
    check("async_rst_state", int'(dbg_state), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("no_done_after_reset", done_cnt, base);
    run_pass("pass_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
